// File: rtl/regfile.sv
// 32 x 64-bit register file with X31 hardwired to zero (XZR), two combinational
// read ports with same-cycle write-through bypass, and synchronous reset.
module regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  WriteRegister,
    input  logic [63:0] WriteData,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    output logic [63:0] ReadData1,
    output logic [63:0] ReadData2
);

    logic [63:0] regs_q [31];
    logic [63:0] regs_d [31];
    logic [31:0] wr_en;
    logic        bypass_ok;
    logic [63:0] mux1;
    logic [63:0] mux2;

    // One-hot write decode; slot 31 never enables since XZR has no storage.
    always_comb begin
        wr_en = '0;
        for (int unsigned i = 0; i < 31; i++) begin
            wr_en[i] = RegWrite && (WriteRegister == 5'(i));
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 31; i++) begin
            regs_d[i] = wr_en[i] ? WriteData : regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 31; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 31; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // 32:1 read muxes with input 31 left at zero.
    always_comb begin
        mux1 = '0;
        mux2 = '0;
        for (int unsigned i = 0; i < 31; i++) begin
            if (ReadRegister1 == 5'(i)) mux1 = regs_q[i];
            if (ReadRegister2 == 5'(i)) mux2 = regs_q[i];
        end
    end

    // Bypass ignores reset: only stored state is cleared during a reset cycle.
    assign bypass_ok = RegWrite && (WriteRegister != 5'd31);

    always_comb begin
        ReadData1 = mux1;
        ReadData2 = mux2;
        if (bypass_ok && (WriteRegister == ReadRegister1)) ReadData1 = WriteData;
        if (bypass_ok && (WriteRegister == ReadRegister2)) ReadData2 = WriteData;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32 registers x 64 bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port RegWrite, input, 1, write enable.
REQ-005 The block SHALL have port WriteRegister, input, 5, destination register index.
REQ-006 The block SHALL have port WriteData, input, 64, value to write.
REQ-007 The block SHALL have port ReadRegister1, input, 5, index for read port 1, feeding ALU operand A.
REQ-008 The block SHALL have port ReadRegister2, input, 5, index for read port 2, feeding ALU operand B.
REQ-009 The block SHALL have port ReadData1, output, 64, contents selected by ReadRegister1.
REQ-010 The block SHALL have port ReadData2, output, 64, contents selected by ReadRegister2.

Function
REQ-011 The block SHALL hold registers X0..X30 as 64-bit state; X31 SHALL be XZR, with no storage.
REQ-012 On a rising edge with reset=0 and RegWrite=1, the block SHALL load WriteData into register WriteRegister when WriteRegister != 31.
REQ-013 A write with WriteRegister=31 SHALL be discarded; no register SHALL change.
REQ-014 With RegWrite=0, no register SHALL change on any edge.
REQ-015 Reads SHALL be combinational: ReadDataN SHALL reflect the current register contents with zero-cycle latency after ReadRegisterN changes.
REQ-016 ReadDataN SHALL be 64'h0 whenever ReadRegisterN=31, regardless of any write activity.
REQ-017 Write-through bypass: when RegWrite=1, WriteRegister != 31 and WriteRegister==ReadRegisterN, ReadDataN SHALL equal WriteData in the same cycle, before the edge.
REQ-018 Bypass SHALL apply independently to both ports; both ports reading the write target SHALL both return WriteData.
REQ-019 Both read ports MAY select the same index; each SHALL return identical data.
REQ-020 Write enables SHALL be decoded from WriteRegister by a 5:32 decoder gated by RegWrite; at most one register SHALL be enabled per cycle.
REQ-021 Read selection SHALL use a 32:1 mux per bit per port, with input 31 tied to 0.
REQ-022 Each storage bit SHALL be a D flip-flop with enable, built as flop plus 2:1 hold mux; no latches are permitted.

Reset
REQ-023 On a rising edge with reset=1, all of X0..X30 SHALL become 64'h0.
REQ-024 Reset SHALL take priority over a simultaneous write; the write SHALL be lost.
REQ-025 During a reset cycle the bypass SHALL still present WriteData combinationally if REQ-017 holds; only the stored state is cleared.
REQ-026 Reset asserted mid-sequence SHALL clear all prior writes; writes after reset deasserts SHALL behave per REQ-012.

Verification
REQ-027 Reset for 1 cycle, then read all 32 indices on both ports -> every ReadData = 64'h0.
REQ-028 For i=0..30, write 64'hA5A5_0000_0000_0000 | i to Xi, then read back on both ports -> exact values; index 31 reads 0.
REQ-029 RegWrite=1, WriteRegister=31, WriteData='1, then read 31 -> 0; X0..X30 are unchanged.
REQ-030 Same cycle: RegWrite=1, WriteRegister=5, WriteData=64'h1234, ReadRegister1=ReadRegister2=5, with X5 previously 0 -> both ReadData = 64'h1234 before the edge and after it.
REQ-031 RegWrite=0, WriteRegister=7, WriteData=64'hFFFF -> X7 is unchanged and no bypass occurs.
REQ-032 Write X3=64'h42, then assert reset together with RegWrite=1, WriteRegister=3, WriteData=64'h99 -> after the edge X3 reads 0.
